// File: rtl/arbitro_rr_sched.sv
// Round-robin scheduler for the 4x4 switch: picks one input FIFO head per
// cycle, honours output back-pressure, and issues registered pop/push pulses.
module arbitro_rr_sched #(
    parameter int DATA_W = 8,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              enable,
    input  logic [3:0]        empty_in,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic [DEST_W-1:0] dest_in0,
    input  logic [DEST_W-1:0] dest_in1,
    input  logic [DEST_W-1:0] dest_in2,
    input  logic [DEST_W-1:0] dest_in3,
    input  logic [3:0]        afull_out,
    output logic [3:0]        pop,
    output logic [3:0]        push,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic [DEST_W-1:0] dest_out,
    output logic              err_dest,
    output logic [7:0]        drop_cnt,
    output logic              idle
);

    typedef enum logic {
        IDLE = 1'b0,
        ARB  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [3:0]        hold_q, hold_d;
    logic [3:0]        pop_q, pop_d;
    logic [3:0]        push_q, push_d;
    logic [DATA_W-1:0] data_q [4];
    logic [DATA_W-1:0] data_d [4];
    logic [DEST_W-1:0] dest_q, dest_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [DATA_W-1:0] din [4];
    logic [DEST_W-1:0] dst [4];
    logic [3:0]        elig;
    logic [3:0]        dst_bad;
    logic              gnt_v;
    logic [1:0]        gnt_idx;
    logic [1:0]        cand;
    logic [1:0]        gnt_port;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;
    assign dst[0] = dest_in0;
    assign dst[1] = dest_in1;
    assign dst[2] = dest_in2;
    assign dst[3] = dest_in3;

    // Invalid destinations stay eligible so they can be drained and dropped.
    always_comb begin
        elig    = '0;
        dst_bad = '0;
        for (int i = 0; i < 4; i++) begin
            dst_bad[i] = dst[i] > DEST_W'(3);
            elig[i] = !empty_in[i] && !hold_q[i] &&
                      (dst_bad[i] || !afull_out[dst[i][1:0]]);
        end
    end

    always_comb begin
        gnt_v   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr_q + 2'(k);
            if (enable && elig[cand]) begin
                gnt_v   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_port = dst[gnt_idx][1:0];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = '0;
        pop_d    = '0;
        push_d   = '0;
        dest_d   = dest_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        for (int j = 0; j < 4; j++) begin
            data_d[j] = data_q[j];
        end

        case (state_q)
            IDLE: if (gnt_v) state_d = ARB;
            ARB:  if (!gnt_v) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (gnt_v) begin
            rr_ptr_d         = gnt_idx + 2'd1;
            hold_d[gnt_idx]  = 1'b1;
            pop_d[gnt_idx]   = 1'b1;
            if (dst_bad[gnt_idx]) begin
                err_d = 1'b1;
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end else begin
                push_d[gnt_port] = 1'b1;
                data_d[gnt_port] = din[gnt_idx];
                dest_d           = dst[gnt_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            hold_q   <= '0;
            pop_q    <= '0;
            push_q   <= '0;
            dest_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            for (int j = 0; j < 4; j++) begin
                data_q[j] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            pop_q    <= pop_d;
            push_q   <= push_d;
            dest_q   <= dest_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            for (int j = 0; j < 4; j++) begin
                data_q[j] <= data_d[j];
            end
        end
    end

    assign pop       = pop_q;
    assign push      = push_q;
    assign data_out0 = data_q[0];
    assign data_out1 = data_q[1];
    assign data_out2 = data_q[2];
    assign data_out3 = data_q[3];
    assign dest_out  = dest_q;
    assign err_dest  = err_q;
    assign drop_cnt  = cnt_q;
    assign idle      = (state_q == IDLE);

endmodule

// File: tb/tb_arbitro_rr_sched.sv
// Randomised and directed bench for arbitro_rr_sched against a
// round-robin reference model.
module tb_arbitro_rr_sched;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       enable;
    logic [3:0] empty_in;
    logic [7:0] di [4];
    logic [3:0] de [4];
    logic [3:0] afull_out;
    logic [3:0] pop, push;
    logic [7:0] dout [4];
    logic [3:0] dest_out;
    logic       err_dest;
    logic [7:0] drop_cnt;
    logic       idle;

    int n_chk = 0;
    int n_bad = 0;

    int m_ptr, m_last, m_cnt, m_gnt;
    int m_data [4];
    int m_dest;

    always #5 clk = ~clk;

    arbitro_rr_sched dut (
        .clk(clk), .reset_L(reset_L), .enable(enable),
        .empty_in(empty_in),
        .data_in0(di[0]), .data_in1(di[1]),
        .data_in2(di[2]), .data_in3(di[3]),
        .dest_in0(de[0]), .dest_in1(de[1]),
        .dest_in2(de[2]), .dest_in3(de[3]),
        .afull_out(afull_out),
        .pop(pop), .push(push),
        .data_out0(dout[0]), .data_out1(dout[1]),
        .data_out2(dout[2]), .data_out3(dout[3]),
        .dest_out(dest_out), .err_dest(err_dest),
        .drop_cnt(drop_cnt), .idle(idle)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_last = -1;
        m_cnt  = 0;
        m_dest = 0;
        m_gnt  = -1;
        for (int j = 0; j < 4; j++) m_data[j] = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pop"}, 32'(pop), 0);
        check({tag, "_push"}, 32'(push), 0);
        check({tag, "_idle"}, 32'(idle), 1);
        check({tag, "_err"}, 32'(err_dest), 0);
        check({tag, "_cnt"}, 32'(drop_cnt), 0);
        check({tag, "_dest"}, 32'(dest_out), 0);
        for (int j = 0; j < 4; j++) check({tag, "_dout"}, 32'(dout[j]), 0);
    endtask

    // Predict the decision for the coming edge, clock it, then compare.
    task automatic step(input string tag);
        int g;
        int ep, eu, ee;
        int i;
        g = -1;
        if (enable) begin
            for (int k = 0; k < 4; k++) begin
                i = (m_ptr + k) % 4;
                if (g < 0 && !empty_in[i] && i != m_last &&
                    (de[i] > 3 || !afull_out[de[i] % 4])) g = i;
            end
        end
        ep = 0; eu = 0; ee = 0;
        if (g >= 0) begin
            ep = 1 << g;
            m_ptr = (g + 1) % 4;
            if (de[g] > 3) begin
                ee = 1;
                if (m_cnt < 255) m_cnt++;
            end else begin
                eu = 1 << de[g];
                m_data[de[g]] = di[g];
                m_dest = de[g];
            end
        end
        m_last = g;
        m_gnt  = g;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_pop"}, 32'(pop), ep);
        check({tag, "_push"}, 32'(push), eu);
        check({tag, "_err"}, 32'(err_dest), ee);
        check({tag, "_cnt"}, 32'(drop_cnt), m_cnt);
        check({tag, "_idle"}, 32'(idle), (g < 0) ? 1 : 0);
        check({tag, "_dest"}, 32'(dest_out), m_dest);
        check({tag, "_push1h"}, 32'($countones(push) <= 1), 1);
        for (int j = 0; j < 4; j++) check({tag, "_dout"}, 32'(dout[j]), m_data[j]);
    endtask

    task automatic set_all(input logic [3:0] e, input logic [3:0] d);
        empty_in = e;
        for (int j = 0; j < 4; j++) begin
            de[j] = d;
            di[j] = 8'(16 * j + 1);
        end
    endtask

    initial begin
        reset_L = 1'b0;
        enable = 1'b1;
        afull_out = 4'b0;
        set_all(4'hF, 4'd0);
        model_reset();
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        reset_L = 1'b1;

        // single source, holdoff alternation
        set_all(4'b1110, 4'd0);
        de[0] = 4'd2;
        di[0] = 8'hA5;
        for (int c = 0; c < 6; c++) step("single");
        check("single_d2", 32'(dout[2]), 32'hA5);

        // fairness
        set_all(4'b0000, 4'd1);
        for (int c = 0; c < 8; c++) step("fair");

        // back-pressure
        set_all(4'b0000, 4'd3);
        afull_out = 4'b1000;
        for (int c = 0; c < 4; c++) step("bp");
        check("bp_idle", 32'(idle), 1);
        afull_out = 4'b0000;
        for (int c = 0; c < 4; c++) step("bp_rel");

        // invalid destination, saturation
        set_all(4'b1101, 4'd0);
        de[1] = 4'd9;
        for (int c = 0; c < 600; c++) step("drop");
        check("drop_sat", 32'(drop_cnt), 255);

        // reset while a push is in flight
        set_all(4'b1111, 4'd0);
        for (int c = 0; c < 2; c++) step("pre");
        set_all(4'b1110, 4'd2);
        di[0] = 8'h5A;
        step("inflt");
        check("inflt_push", 32'(push), 32'h4);
        reset_L = 1'b0;
        #1;
        model_reset();
        check_reset_vals("midrst");
        #1;
        reset_L = 1'b1;
        set_all(4'b0000, 4'd1);
        step("post");
        check("post_ptr0", 32'(pop), 1);
        reset_L = 1'b0;
        #1;
        model_reset();
        reset_L = 1'b1;

        // mixed targets, heads drained as they are granted
        empty_in = 4'b0010;
        de[0] = 4'd0; di[0] = 8'h11;
        de[1] = 4'd0; di[1] = 8'h00;
        de[2] = 4'd0; di[2] = 8'h22;
        de[3] = 4'd3; di[3] = 8'h33;
        for (int c = 0; c < 6; c++) begin
            step("mix");
            if (m_gnt >= 0) empty_in[m_gnt] = 1'b1;
        end
        check("mix_d0", 32'(dout[0]), 32'h22);
        check("mix_d3", 32'(dout[3]), 32'h33);

        // random
        for (int c = 0; c < 1500; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            empty_in = 4'($urandom);
            afull_out = 4'($urandom) & 4'($urandom);
            for (int j = 0; j < 4; j++) begin
                di[j] = 8'($urandom);
                de[j] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15))
                                                   : 4'($urandom_range(0, 3));
            end
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/arbitro_rr_sched.md
Name: arbitro_rr_sched

Overview:
- Round-robin scheduler/controller for the 4x4 transaction-layer switch datapath.
- Sits between four show-ahead input FIFOs (VC0..VC3) and four output FIFOs (ports 0..3).
- Each cycle it selects at most one input FIFO with a valid head, checks that the destination output FIFO has room, then issues one pop and one push and moves the head byte to the addressed output.
- Replaces fixed slot-counter sequencing with fair, back-pressure-aware arbitration.

Parameters:
- DATA_W, 8, width of data bytes.
- DEST_W, 4, width of destination field. Only values 0..3 are valid.

Ports:
- clk  input  1  clock, rising edge
- reset_L  input  1  asynchronous, active-low reset
- enable  input  1  1 = arbitrate; 0 = issue no grants (pipeline drains)
- empty_in  input  4  input FIFO empty flags; bit i = FIFO i
- data_in0..data_in3  input  DATA_W each  head data of input FIFO i (show-ahead)
- dest_in0..dest_in3  input  DEST_W each  head destination of input FIFO i
- afull_out  input  4  output FIFO almost-full flags; asserted when fewer than 2 free entries
- pop  output  4  registered one-hot pop pulse to input FIFOs
- push  output  4  registered one-hot push pulse to output FIFOs
- data_out0..data_out3  output  DATA_W each  registered data to output FIFO j; valid when push[j]=1
- dest_out  output  DEST_W  destination of the last grant (debug)
- err_dest  output  1  one-cycle pulse: entry with invalid destination was dropped
- drop_cnt  output  8  saturating count of dropped entries
- idle  output  1  1 when state is IDLE

Behaviour:
- Reset (reset_L=0, asynchronous) sets:
  - pop, push = 0
  - data_out0..3 = 0, dest_out = 0
  - err_dest = 0, drop_cnt = 0, idle = 1
  - rr_ptr = 0, holdoff mask = 0, state = IDLE
- Reset mid-transfer: any pulse in flight is cleared immediately. No partial push may survive.
- All outputs are registered. A grant decided at edge N appears as pop/push during cycle N..N+1. Latency from head valid to push is 1 clk.
- Eligibility of requester i requires all of:
  - empty_in[i] = 0
  - holdoff[i] = 0
  - either dest_in_i > 3, or afull_out[dest_in_i] = 0
- Selection: first eligible i, searching rr_ptr, rr_ptr+1, ... modulo 4.
- On a grant to i: rr_ptr <= i+1, wrapping 3 -> 0. Ungranted cycles leave rr_ptr unchanged.
- Holdoff: the requester granted at edge N has holdoff=1 for the next decision only. This covers the stale show-ahead head while the registered pop takes effect. Other requesters may be granted back-to-back, so sustained throughput is 1 entry/clk with at least 2 active inputs and 1 entry per 2 clk with a single active input.
- Valid destination d (0..3):
  - pop[i] = 1, push[d] = 1, data_out_d = data_in_i, dest_out = d
  - other data_out hold their previous value.
- Invalid destination (>3):
  - pop[i] = 1, push = 0, err_dest = 1
  - drop_cnt increments and saturates at 255.
- afull_out gives a 2-entry margin, which covers the one-cycle lag between the flag and the registered push. The scheduler never pushes to a port whose afull is sampled high.
- At most one bit of pop and at most one bit of push is set in any cycle.
- FSM states:
  - IDLE: no eligible requester, or enable=0. pop=push=0, idle=1. Go to ARB when enable=1 and any eligible requester exists.
  - ARB: a grant is made this edge, idle=0. Stay in ARB while any requester is eligible after holdoff. Otherwise return to IDLE. enable=0 forces IDLE at the next edge; no new grants are made and a pulse already issued completes normally.
- Simultaneous events: empty_in or afull_out changing in the same cycle are sampled at the edge; the sampled values decide the grant.

Test Plan:
1. Reset then single source: after reset all outputs match reset values. empty_in=4'b1110, dest_in0=2, data_in0=8'hA5, afull_out=0 -> next cycle pop=4'b0001, push=4'b0100, data_out2=8'hA5. Grants to VC0 alternate with idle cycles (holdoff).
2. Fairness: empty_in=0, all dest=1, afull_out=0 for 8 clk -> pop sequence 0001, 0010, 0100, 1000 repeating; push=4'b0010 every cycle.
3. Back-pressure: all heads dest=3, afull_out=4'b1000 -> pop=push=0 and state stays IDLE. Deassert afull -> first grant goes to rr_ptr's requester in the next cycle.
4. Invalid destination: dest_in1=4'd9, only VC1 non-empty -> pop=4'b0010, push=0, err_dest=1 for one cycle, drop_cnt=1. After 300 such drops drop_cnt=255.
5. Mixed targets: VC0->0 with 8'h11, VC2->0 with 8'h22, VC3->3 with 8'h33, rr_ptr=0 -> pushes in order port0(11), port0(22), port3(33). No cycle has more than one push bit set.
6. Reset mid-operation: reset_L=0 asynchronously during an ARB cycle with push=4'b0100 -> push and pop drop to 0 immediately, rr_ptr=0, idle=1.
